// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 raster timing defaults and shared types.
package vga_timing_pkg;
  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HS_START  = H_VISIBLE + H_FP;
  localparam int HS_END    = HS_START + H_SYNC;
  localparam int VS_START  = V_VISIBLE + V_FP;
  localparam int VS_END    = VS_START + V_SYNC;

  typedef logic [9:0] coord_t;

  // Half-open range test [lo, hi) on a raster coordinate.
  function automatic logic in_span(coord_t v, int lo, int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction
endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Enable-qualified shift register that realigns sync pulses with renderer colour latency.
module sync_delay_line #(
  parameter int               WIDTH     = 2,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             vga_clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  if (DEPTH == 0) begin : g_wire
    assign q = d;
  end else begin : g_pipe
    logic [DEPTH-1:0][WIDTH-1:0] pipe;

    always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
        pipe <= {DEPTH{RESET_VAL}};
      end else if (en) begin
        pipe[0] <= d;
        for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign q = pipe[DEPTH-1];
  end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters with registered decode of blank/sync/start flags and delayed sync copies.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_VISIBLE  = vga_timing_pkg::H_VISIBLE,
  parameter int   H_FP       = vga_timing_pkg::H_FP,
  parameter int   H_SYNC     = vga_timing_pkg::H_SYNC,
  parameter int   H_BP       = vga_timing_pkg::H_BP,
  parameter int   V_VISIBLE  = vga_timing_pkg::V_VISIBLE,
  parameter int   V_FP       = vga_timing_pkg::V_FP,
  parameter int   V_SYNC     = vga_timing_pkg::V_SYNC,
  parameter int   V_BP       = vga_timing_pkg::V_BP,
  parameter logic SYNC_POL   = 1'b0,
  parameter int   PIPE_DELAY = 2
) (
  input  logic   vga_clk,
  input  logic   reset,
  input  logic   pix_en,
  output coord_t DrawX,
  output coord_t DrawY,
  output logic   blank,
  output logic   hs,
  output logic   vs,
  output logic   hs_dly,
  output logic   vs_dly,
  output logic   frame_start,
  output logic   line_start
);
  localparam int HTOT  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int VTOT  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HS_LO = H_VISIBLE + H_FP;
  localparam int HS_HI = HS_LO + H_SYNC;
  localparam int VS_LO = V_VISIBLE + V_FP;
  localparam int VS_HI = VS_LO + V_SYNC;

  if (HTOT > 1024 || VTOT > 1024) begin : g_range_err
    $error("vga_timing_gen: raster totals exceed 10-bit counters");
  end

  coord_t     hc, vc, hc_nxt, vc_nxt;
  logic       hs_r, vs_r;
  logic [1:0] dly_q;

  always_comb begin
    hc_nxt = hc + 10'd1;
    vc_nxt = vc;
    if (hc == coord_t'(HTOT - 1)) begin
      hc_nxt = '0;
      vc_nxt = (vc == coord_t'(VTOT - 1)) ? '0 : vc + 10'd1;
    end
  end

  // Flags decode the next position so they flip on the same edge as the counters.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hc          <= '0;
      vc          <= '0;
      blank       <= 1'b1;
      hs_r        <= ~SYNC_POL;
      vs_r        <= ~SYNC_POL;
      frame_start <= 1'b1;
      line_start  <= 1'b1;
    end else if (pix_en) begin
      hc          <= hc_nxt;
      vc          <= vc_nxt;
      blank       <= (int'(hc_nxt) < H_VISIBLE) && (int'(vc_nxt) < V_VISIBLE);
      hs_r        <= in_span(hc_nxt, HS_LO, HS_HI) ? SYNC_POL : ~SYNC_POL;
      vs_r        <= in_span(vc_nxt, VS_LO, VS_HI) ? SYNC_POL : ~SYNC_POL;
      frame_start <= (hc_nxt == '0) && (vc_nxt == '0);
      line_start  <= (hc_nxt == '0);
    end
  end

  assign DrawX = hc;
  assign DrawY = vc;
  assign hs    = hs_r;
  assign vs    = vs_r;

  sync_delay_line #(
    .WIDTH     (2),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL ({~SYNC_POL, ~SYNC_POL})
  ) u_sync_dly (
    .vga_clk (vga_clk),
    .reset   (reset),
    .en      (pix_en),
    .d       ({hs_r, vs_r}),
    .q       (dly_q)
  );

  assign hs_dly = dly_q[1];
  assign vs_dly = dly_q[0];
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboarded bench: full-size 640x480 timing (2-stage sync delay) plus a small raster, active-high sync, no delay.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int S_HV = 8, S_HF = 2, S_HS = 3, S_HB = 2;
  localparam int S_VV = 4, S_VF = 1, S_VS = 2, S_VB = 1;
  localparam int S_HT = 15, S_VT = 8;

  logic   vga_clk = 1'b0;
  logic   reset   = 1'b1;
  logic   pix_en  = 1'b1;
  coord_t x0, y0, x1, y1;
  logic   b0, hs0, vs0, hd0, vd0, fs0, ls0;
  logic   b1, hs1, vs1, hd1, vd1, fs1, ls1;

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen #(.SYNC_POL(1'b0), .PIPE_DELAY(2)) dut0 (
    .vga_clk(vga_clk), .reset(reset), .pix_en(pix_en), .DrawX(x0), .DrawY(y0),
    .blank(b0), .hs(hs0), .vs(vs0), .hs_dly(hd0), .vs_dly(vd0),
    .frame_start(fs0), .line_start(ls0));

  vga_timing_gen #(
    .H_VISIBLE(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_VISIBLE(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .SYNC_POL(1'b1), .PIPE_DELAY(0)
  ) dut1 (
    .vga_clk(vga_clk), .reset(reset), .pix_en(pix_en), .DrawX(x1), .DrawY(y1),
    .blank(b1), .hs(hs1), .vs(vs1), .hs_dly(hd1), .vs_dly(vd1),
    .frame_start(fs1), .line_start(ls1));

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic b, hs, vs, hd, vd, fs, ls;
  } obs_t;

  obs_t q0[$], q1[$];
  int   checks = 0, errors = 0;

  // Reference position and dut0 delay stages ({hs,vs} per stage).
  int         m0x, m0y, m1x, m1y;
  logic [1:0] st0, st1;

  function automatic obs_t mk(int x, int y, int hv, int hf, int hsw, int vv, int vf, int vsw,
                              logic pol);
    obs_t e;
    e.x  = x[9:0];
    e.y  = y[9:0];
    e.b  = (x < hv) && (y < vv);
    e.hs = (x >= hv + hf && x < hv + hf + hsw) ? pol : ~pol;
    e.vs = (y >= vv + vf && y < vv + vf + vsw) ? pol : ~pol;
    e.hd = 1'b0;
    e.vd = 1'b0;
    e.fs = (x == 0) && (y == 0);
    e.ls = (x == 0);
    return e;
  endfunction

  function automatic obs_t exp0();
    obs_t e = mk(m0x, m0y, 640, 16, 96, 480, 10, 2, 1'b0);
    e.hd = st1[1];
    e.vd = st1[0];
    return e;
  endfunction

  function automatic obs_t exp1();
    obs_t e = mk(m1x, m1y, S_HV, S_HF, S_HS, S_VV, S_VF, S_VS, 1'b1);
    e.hd = e.hs;
    e.vd = e.vs;
    return e;
  endfunction

  task automatic model_edge(input logic rst, input logic pe);
    obs_t c;
    if (rst) begin
      m0x = 0; m0y = 0; m1x = 0; m1y = 0;
      st0 = 2'b11; st1 = 2'b11;
    end else if (pe) begin
      c   = exp0();
      st1 = st0;
      st0 = {c.hs, c.vs};
      if (m0x == 799) begin m0x = 0; m0y = (m0y == 524) ? 0 : m0y + 1; end
      else m0x++;
      if (m1x == S_HT - 1) begin m1x = 0; m1y = (m1y == S_VT - 1) ? 0 : m1y + 1; end
      else m1x++;
    end
    q0.push_back(exp0());
    q1.push_back(exp1());
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: one scoreboard entry per clock, compared on the falling edge.
  always @(negedge vga_clk) begin
    obs_t e, a;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      a = {x0, y0, b0, hs0, vs0, hd0, vd0, fs0, ls0};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL dut0 obs @%0t: got %h expected %h", $time, a, e);
      end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      a = {x1, y1, b1, hs1, vs1, hd1, vd1, fs1, ls1};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL dut1 obs @%0t: got %h expected %h", $time, a, e);
      end
    end
  end

  // dut1 frame measurements: period between frame_start rises and vs-active cycles per frame.
  int   cyc = 0, last_rise = 0, last_period = 0, vs_cnt = 0, last_vs_cnt = 0;
  logic pfs1 = 1'b1;

  task automatic step(input logic pe);
    pix_en = pe;
    @(posedge vga_clk);
    model_edge(reset, pe);
    #2;
    cyc++;
    if (fs1 && !pfs1) begin
      if (last_rise > 0) begin
        last_period = cyc - last_rise;
        last_vs_cnt = vs_cnt;
      end
      last_rise = cyc;
      vs_cnt    = 0;
    end
    if (vs1) vs_cnt++;
    pfs1 = fs1;
  endtask

  task automatic meas_clear();
    last_rise = 0; last_period = 0; vs_cnt = 0; last_vs_cnt = 0; pfs1 = 1'b1;
  endtask

  task automatic hit_reset();
    @(negedge vga_clk);
    #1 reset = 1'b1;
    #1;
    chk("rst DrawX", int'(x0), 0);
    chk("rst DrawY", int'(y0), 0);
    chk("rst blank", int'(b0), 1);
    chk("rst hs/vs", int'({hs0, vs0}), 3);
    chk("rst dly", int'({hd0, vd0}), 3);
    chk("rst frame_start", int'(fs0), 1);
    chk("rst line_start", int'(ls0), 1);
    chk("rst small hs/vs", int'({hs1, vs1, hd1, vd1}), 0);
    @(posedge vga_clk);
    model_edge(1'b1, pix_en);
    #2 reset = 1'b0;
    meas_clear();
  endtask

  int hs_low, first_hs, first_blank0;

  initial begin
    // Power-on reset
    @(posedge vga_clk);
    model_edge(1'b1, 1'b1);
    #2 reset = 1'b0;

    // Run to hc=300 on line 0, then reset mid-line.
    for (int i = 0; i < 300; i++) step(1'b1);
    chk("pre-reset DrawX", int'(x0), 300);
    hit_reset();

    // One full line from reset.
    hs_low = 0; first_hs = -1; first_blank0 = -1;
    for (int i = 0; i < 799; i++) begin
      step(1'b1);
      if (!hs0) begin
        hs_low++;
        if (first_hs < 0) first_hs = int'(x0);
      end
      if (!b0 && first_blank0 < 0) first_blank0 = int'(x0);
    end
    chk("hs low cycles", hs_low, 96);
    chk("hs first DrawX", first_hs, 656);
    chk("blank fall DrawX", first_blank0, 640);
    chk("end of line DrawX", int'(x0), 799);
    step(1'b1);
    chk("wrap DrawX", int'(x0), 0);
    chk("wrap DrawY", int'(y0), 1);
    chk("wrap line_start", int'(ls0), 1);
    step(1'b1);
    chk("line_start one cycle", int'(ls0), 0);
    chk("small frame period", last_period, 120);
    chk("small vs active cycles", last_vs_cnt, 30);

    // Alternating pix_en: positions hold on idle cycles, frame doubles in length.
    meas_clear();
    for (int i = 0; i < 960; i++) step((i % 2) == 0);
    chk("gated frame period", last_period, 240);
    chk("gated vs active cycles", last_vs_cnt, 60);

    // Hold with pix_en low for a stretch.
    for (int i = 0; i < 10; i++) step(1'b0);
    for (int i = 0; i < 20; i++) step(1'b1);

    @(negedge vga_clk);
    #1;
    chk("scoreboard drained", q0.size() + q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
